seq_scan_ctrl: RTL and testbench

- Frame controller for the serial sequence-check path.
- Accepts a frame of parallel words over a valid/ready handshake and serialises each word MSB-first, one bit per clock.
- Feeds the bits to an internal programmable pattern matcher and counts pattern hits per frame. Overlapping matches are counted.
- Reports BUSY and DONE to the host sequencer, and the hit count.

---
 rtl/seq_scan_ctrl_pkg.sv | 7 +
 rtl/seq_scan_ctrl_match.sv | 36 +++
 rtl/seq_scan_ctrl.sv | 90 +++++++++
 tb/tb_seq_scan_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_ctrl_pkg.sv
// seq_scan_ctrl_pkg: shared state encoding and default sizes for the sequence-check path.
package seq_scan_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, FIN} state_t;
    localparam int W_DEF = 8;
    localparam int N_DEF = 8;
    localparam int C_DEF = 8;
endpackage

// File: rtl/seq_scan_ctrl_match.sv
// seq_match: sliding N-bit window over the serial stream, flags a pattern hit one cycle after each completing bit.
module seq_match import seq_scan_ctrl_pkg::*; #(
    parameter int N = N_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         bit_in,
    input  logic [N-1:0] pat,
    output logic         hit
);
    localparam int BW = $clog2(N + 1);
    logic [N-1:0]  window;
    logic [BW-1:0] bitcnt;
    logic          new_bit;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            window  <= '0;
            bitcnt  <= '0;
            new_bit <= 1'b0;
        end else if (clear) begin
            window  <= '0;
            bitcnt  <= '0;
            new_bit <= 1'b0;
        end else begin
            new_bit <= shift_en;
            if (shift_en) begin
                window <= {window[N-2:0], bit_in};
                bitcnt <= (bitcnt == BW'(N)) ? bitcnt : bitcnt + BW'(1);
            end
        end
    end
    // bitcnt saturates at N, so equality means a full window of frame bits
    assign hit = new_bit && (bitcnt == BW'(N)) && (window == pat);
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame controller that serialises words MSB-first and counts pattern hits per frame.
module seq_scan_ctrl import seq_scan_ctrl_pkg::*; #(
    parameter int W = W_DEF,
    parameter int N = N_DEF,
    parameter int C = C_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         ABORT,
    input  logic [7:0]   NWORDS,
    input  logic [N-1:0] PAT,
    input  logic [W-1:0] DIN,
    input  logic         DIN_VALID,
    output logic         DIN_READY,
    output logic         SDOUT,
    output logic         SVALID,
    output logic         HIT,
    output logic [C-1:0] HIT_CNT,
    output logic         BUSY,
    output logic         DONE
);
    localparam int IW = $clog2(W);
    state_t        state, state_nx;
    logic [W-1:0]  sreg;
    logic [IW-1:0] bidx;
    logic [7:0]    nw_r;
    logic [N-1:0]  pat_r;
    logic          start_ok, load_ok, word_end, mclear;
    always_comb begin
        state_nx = state;
        start_ok = (state == IDLE) && START && !ABORT;
        load_ok  = (state == LOAD) && DIN_VALID && !ABORT;
        word_end = (state == SHIFT) && (bidx == '0);
        mclear   = ABORT || ((state == IDLE) && START);
        case (state)
            IDLE:    state_nx = START ? ((NWORDS != '0) ? LOAD : FIN) : IDLE;
            LOAD:    state_nx = DIN_VALID ? SHIFT : LOAD;
            SHIFT:   state_nx = word_end ? ((nw_r == 8'd1) ? DRAIN : LOAD) : SHIFT;
            DRAIN:   state_nx = FIN;
            default: state_nx = IDLE;
        endcase
        if (ABORT) state_nx = IDLE;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end
    assign DIN_READY = (state == LOAD);
    assign SVALID    = (state == SHIFT);
    assign SDOUT     = SVALID && sreg[W-1];
    assign BUSY      = (state != IDLE);
    assign DONE      = (state == FIN);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sreg    <= '0;
            bidx    <= '0;
            nw_r    <= '0;
            pat_r   <= '0;
            HIT_CNT <= '0;
        end else begin
            if (start_ok) begin
                HIT_CNT <= '0;
                if (NWORDS != '0) begin
                    pat_r <= PAT;
                    nw_r  <= NWORDS;
                end
            end else if (!ABORT && HIT && (HIT_CNT != '1)) begin
                HIT_CNT <= HIT_CNT + C'(1);
            end
            if (load_ok) begin
                sreg <= DIN;
                bidx <= IW'(W - 1);
            end else if (state == SHIFT) begin
                sreg <= sreg << 1;
                bidx <= bidx - IW'(1);
                if (word_end) nw_r <= nw_r - 8'd1;
            end
        end
    end
    seq_match #(.N(N)) u_match (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (mclear),
        .shift_en (SVALID),
        .bit_in   (SDOUT),
        .pat      (pat_r),
        .hit      (HIT)
    );
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: scoreboard bench for seq_scan_ctrl; a monitor pops expected bits, hit positions and final counts.
module tb_seq_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, abort = 1'b0, din_valid = 1'b0;
    logic [7:0] nwords = '0, pat_i = '0, din = '0;
    logic       din_ready, sdout, svalid, hit, busy, done;
    logic [7:0] hit_cnt;
    logic       s_start = 1'b0, s_din_valid = 1'b0;
    logic       s_din_ready, s_sdout, s_svalid, s_hit, s_busy, s_done;
    logic [1:0] s_hit_cnt;
    int         compared = 0, mismatched = 0, fbits = 0;
    logic       exp_bits[$];
    int         exp_hit[$];
    int         exp_done[$];

    always #5 clk = ~clk;

    seq_scan_ctrl u_dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .NWORDS(nwords), .PAT(pat_i),
        .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready), .SDOUT(sdout), .SVALID(svalid),
        .HIT(hit), .HIT_CNT(hit_cnt), .BUSY(busy), .DONE(done)
    );

    seq_scan_ctrl #(.C(2)) u_sat (
        .CLK(clk), .RST(rst), .START(s_start), .ABORT(1'b0), .NWORDS(8'd2), .PAT(8'hFF),
        .DIN(8'hFF), .DIN_VALID(s_din_valid), .DIN_READY(s_din_ready), .SDOUT(s_sdout), .SVALID(s_svalid),
        .HIT(s_hit), .HIT_CNT(s_hit_cnt), .BUSY(s_busy), .DONE(s_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(w[i]);
    endtask

    always @(negedge clk) begin
        if (!rst) fbits = 0;
        else begin
            if (hit) begin
                if (exp_hit.size() == 0) chk("hit_unexpected", 32'(hit), 0);
                else chk("hit_pos", fbits, exp_hit.pop_front());
            end
            if (svalid) begin
                if (exp_bits.size() == 0) chk("bit_unexpected", 32'(svalid), 0);
                else chk("sdout", 32'(sdout), 32'(exp_bits.pop_front()));
                fbits++;
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 0);
                else chk("done_cnt", 32'(hit_cnt), exp_done.pop_front());
            end
            if (!busy) fbits = 0;
        end
    end

    task automatic run_frame(input logic [7:0] p, input logic [7:0] nw, input logic [7:0] w0, input logic [7:0] w1);
        int n;
        @(posedge clk); #1;
        pat_i = p; nwords = nw; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("cnt_clear", 32'(hit_cnt), 0);
        for (int i = 0; i < 32'(nw); i++) begin
            din = (i == 0) ? w0 : w1;
            din_valid = 1'b1;
            n = 0;
            while (!din_ready && n < 50) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("frame_end_busy", 32'(busy), 0);
    endtask

    // cycle 0 carries START; DIN_VALID is withheld for d extra LOAD cycles
    task automatic timing_run(input int d);
        push_word(8'hA5);
        exp_done.push_back(0);
        for (int c = 0; c <= 12 + d; c++) begin
            @(posedge clk); #1;
            start = (c == 0); din_valid = (c >= 1 + d); nwords = 8'd1; pat_i = 8'hFF; din = 8'hA5;
            @(negedge clk);
            chk($sformatf("busy_c%0d_d%0d", c, d), 32'(busy), 32'(c >= 1 && c <= 11 + d));
            chk($sformatf("ready_c%0d_d%0d", c, d), 32'(din_ready), 32'(c >= 1 && c <= 1 + d));
            chk($sformatf("svalid_c%0d_d%0d", c, d), 32'(svalid), 32'(c >= 2 + d && c <= 9 + d));
            chk($sformatf("done_c%0d_d%0d", c, d), 32'(done), 32'(c == 11 + d));
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    initial begin
        int hits;
        logic seen;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(din_ready), 0);
        chk("rst_svalid", 32'(svalid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_hit_cnt", 32'(hit_cnt), 0);
        chk("rst_s_busy", 32'(s_busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        push_word(8'hD3); push_word(8'h00);
        exp_hit.push_back(8);
        exp_done.push_back(1);
        run_frame(8'hD3, 8'd2, 8'hD3, 8'h00);

        push_word(8'hAA); push_word(8'hAA);
        foreach (exp_hit[i]) ;
        for (int k = 8; k <= 16; k += 2) exp_hit.push_back(k);
        exp_done.push_back(5);
        run_frame(8'hAA, 8'd2, 8'hAA, 8'hAA);

        exp_done.push_back(0);
        @(posedge clk); #1;
        nwords = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 1);
        chk("zero_ready", 32'(din_ready), 0);
        chk("zero_svalid", 32'(svalid), 0);
        chk("zero_cnt", 32'(hit_cnt), 0);
        @(posedge clk); #1;
        chk("zero_idle", 32'(busy), 0);

        timing_run(0);
        timing_run(5);

        push_word(8'h3C);
        for (int i = 0; i < 3; i++) exp_bits.push_back(1'b0);
        exp_hit.push_back(8);
        @(posedge clk); #1;
        pat_i = 8'h3C; nwords = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din = 8'h3C; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        din = 8'h00; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_svalid", 32'(svalid), 0);
        chk("abort_ready", 32'(din_ready), 0);
        chk("abort_cnt_held", 32'(hit_cnt), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done), 0);

        push_word(8'hD3); push_word(8'h00);
        exp_hit.push_back(8);
        exp_done.push_back(1);
        run_frame(8'hD3, 8'd2, 8'hD3, 8'h00);

        s_din_valid = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        hits = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (s_hit) hits++;
            if (s_done) seen = 1'b1;
        end
        chk("sat_done_seen", 32'(seen), 1);
        chk("sat_hits", hits, 9);
        chk("sat_cnt", 32'(s_hit_cnt), 3);

        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("pre_rst_svalid", 32'(s_svalid), 1);
        chk("pre_rst_cnt", 32'(s_hit_cnt), 3);
        rst = 1'b0;
        #1;
        chk("arst_cnt", 32'(s_hit_cnt), 0);
        chk("arst_busy", 32'(s_busy), 0);
        chk("arst_svalid", 32'(s_svalid), 0);
        chk("arst_sdout", 32'(s_sdout), 0);
        chk("arst_ready", 32'(s_din_ready), 0);
        chk("arst_done_hit", 32'({s_done, s_hit}), 0);
        chk("arst_main_cnt", 32'(hit_cnt), 0);
        s_din_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("left_bits", exp_bits.size(), 0);
        chk("left_hits", exp_hit.size(), 0);
        chk("left_done", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
